// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM state encoding,
// next-PC select encoding and the sequential increment.
package pc_seq_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StTrap
    } seq_state_e;

    typedef enum logic [2:0] {
        SelHold,
        SelSeq,
        SelBr,
        SelJ,
        SelJr,
        SelTrap
    } next_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder/hazard logic (master) and the
// next-PC sequencer (slave).
interface pc_sequencer_if;

    logic        stall;
    logic        branch_en;
    logic        branch_cond;
    logic [15:0] branch_offset;
    logic        jump_en;
    logic [25:0] jump_target;
    logic        jr_en;
    logic [31:0] jr_addr;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect;
    logic        trap;
    logic [31:0] epc;

    modport master (
        output stall, branch_en, branch_cond, branch_offset,
        output jump_en, jump_target, jr_en, jr_addr,
        input  pc, pc_plus4, pc_valid, redirect, trap, epc
    );

    modport slave (
        input  stall, branch_en, branch_cond, branch_offset,
        input  jump_en, jump_target, jr_en, jr_addr,
        output pc, pc_plus4, pc_valid, redirect, trap, epc
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC datapath: increment, branch/jump/jr targets and the
// priority select. Misaligned-jr detection exists only with PC_SEQ_ALIGN_TRAP_EN.
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        branch_en_i,
    input  logic        branch_cond_i,
    input  logic [15:0] branch_offset_i,
    input  logic        jump_en_i,
    input  logic [25:0] jump_target_i,
    input  logic        jr_en_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output next_sel_e   sel_o
);

    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        jr_misaligned;

`ifdef PC_SEQ_ALIGN_TRAP_EN
    assign jr_target     = jr_addr_i;
    assign jr_misaligned = |jr_addr_i[1:0];
`else
    // Low bits are forced to zero instead of trapping.
    logic unused_jr_lsbs;
    assign unused_jr_lsbs = ^jr_addr_i[1:0];
    assign jr_target      = {jr_addr_i[31:2], 2'b00};
    assign jr_misaligned  = 1'b0;
`endif

    assign pc_plus4_o = pc_i + PC_INCR;
    assign br_target  = pc_plus4_o + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign j_target   = {pc_plus4_o[31:28], jump_target_i, 2'b00};

    always_comb begin
        sel_o     = SelSeq;
        next_pc_o = pc_plus4_o;
        if (stall_i) begin
            sel_o     = SelHold;
            next_pc_o = pc_i;
        end else if (jr_en_i) begin
            sel_o     = jr_misaligned ? SelTrap : SelJr;
            next_pc_o = jr_target;
        end else if (jump_en_i) begin
            sel_o     = SelJ;
            next_pc_o = j_target;
        end else if (branch_en_i && branch_cond_i) begin
            sel_o     = SelBr;
            next_pc_o = br_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register, BOOT/RUN/TRAP FSM and registered redirect/trap pulses.
// Optional misaligned jump-register trap enabled by defining PC_SEQ_ALIGN_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_ADDR  = 32'h0000_0080
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    next_sel_e   sel;

    pc_next_calc u_next_calc (
        .pc_i            (pc_q),
        .stall_i         (bus.stall),
        .branch_en_i     (bus.branch_en),
        .branch_cond_i   (bus.branch_cond),
        .branch_offset_i (bus.branch_offset),
        .jump_en_i       (bus.jump_en),
        .jump_target_i   (bus.jump_target),
        .jr_en_i         (bus.jr_en),
        .jr_addr_i       (bus.jr_addr),
        .pc_plus4_o      (pc_plus4),
        .next_pc_o       (next_pc),
        .sel_o           (sel)
    );

`ifdef PC_SEQ_ALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] epc_q, epc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            epc_q  <= 32'd0;
        end else begin
            trap_q <= trap_d;
            epc_q  <= epc_d;
        end
    end

    assign bus.trap = trap_q;
    assign bus.epc  = epc_q;
`else
    logic unused_trap_addr;
    assign unused_trap_addr = ^TRAP_ADDR;
    assign bus.trap         = 1'b0;
    assign bus.epc          = 32'd0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
        trap_d     = 1'b0;
        epc_d      = epc_q;
`endif
        case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                pc_d       = next_pc;
                redirect_d = sel inside {SelBr, SelJ, SelJr, SelTrap};
`ifdef PC_SEQ_ALIGN_TRAP_EN
                if (sel == SelTrap) begin
                    pc_d    = TRAP_ADDR;
                    epc_d   = bus.jr_addr;
                    trap_d  = 1'b1;
                    state_d = StTrap;
                end
`endif
            end
`ifdef PC_SEQ_ALIGN_TRAP_EN
            // Hold TRAP_ADDR here; RUN fetches it once the stall clears.
            StTrap: if (!bus.stall) state_d = StRun;
`endif
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_ADDR;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.pc_valid = (state_q == StRun);
    assign bus.redirect = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random control traffic, all
// checked against a rule-level reference model of the program counter.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] TRAP_ADDR  = 32'h0000_0080;
`ifdef PC_SEQ_ALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_ADDR (RESET_ADDR),
        .TRAP_ADDR  (TRAP_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_boot;
    bit          m_in_trap;
    bit          m_redirect;
    bit          m_trap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.stall         = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_cond   = 1'b0;
        bus.branch_offset = 16'h0;
        bus.jump_en       = 1'b0;
        bus.jump_target   = 26'h0;
        bus.jr_en         = 1'b0;
        bus.jr_addr       = 32'h0;
    endtask

    task automatic model_reset();
        m_pc       = RESET_ADDR;
        m_epc      = 32'd0;
        m_boot     = 1'b1;
        m_in_trap  = 1'b0;
        m_redirect = 1'b0;
        m_trap     = 1'b0;
    endtask

    // One rising edge of the architectural rules, using the inputs held across it.
    task automatic model_step();
        longint off;
        m_redirect = 1'b0;
        m_trap     = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_in_trap) begin
            if (!bus.stall) m_in_trap = 1'b0;
        end else if (!bus.stall) begin
            if (bus.jr_en) begin
                m_redirect = 1'b1;
                if (TrapEn && (bus.jr_addr % 4) != 0) begin
                    m_pc      = TRAP_ADDR;
                    m_epc     = bus.jr_addr;
                    m_trap    = 1'b1;
                    m_in_trap = 1'b1;
                end else begin
                    m_pc = bus.jr_addr - (bus.jr_addr % 4);
                end
            end else if (bus.jump_en) begin
                m_redirect = 1'b1;
                m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(bus.jump_target) * 32'd4);
            end else if (bus.branch_en && bus.branch_cond) begin
                m_redirect = 1'b1;
                off  = longint'($signed(bus.branch_offset)) * 4;
                m_pc = 32'(longint'(m_pc) + 4 + off);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pc"}, bus.pc, m_pc);
        check_eq({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
        check_eq({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(!m_boot && !m_in_trap));
        check_eq({tag, ".redirect"}, 32'(bus.redirect), 32'(m_redirect));
        check_eq({tag, ".trap"}, 32'(bus.trap), 32'(m_trap));
        check_eq({tag, ".epc"}, bus.epc, m_epc);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic load_pc(input logic [31:0] addr);
        bus.jr_en   = 1'b1;
        bus.jr_addr = addr;
        tick("load");
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_model("reset");
        check_eq("reset_pc", bus.pc, RESET_ADDR);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("boot_valid", 32'(bus.pc_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick("seq");
            check_eq("seq_pc", bus.pc, 32'(i * 4));
            check_eq("seq_redirect", 32'(bus.redirect), 32'd0);
        end
        check_eq("seq_valid", 32'(bus.pc_valid), 32'd1);

        load_pc(32'h0000_0100);
        bus.branch_en     = 1'b1;
        bus.branch_cond   = 1'b1;
        bus.branch_offset = 16'hFFFE;
        tick("br_taken");
        check_eq("br_taken_pc", bus.pc, 32'h0000_00FC);
        check_eq("br_taken_redirect", 32'(bus.redirect), 32'd1);
        set_idle();
        tick("br_after");
        check_eq("br_after_redirect", 32'(bus.redirect), 32'd0);

        load_pc(32'h0000_0100);
        bus.branch_en     = 1'b1;
        bus.branch_cond   = 1'b0;
        bus.branch_offset = 16'hFFFE;
        tick("br_not");
        check_eq("br_not_pc", bus.pc, 32'h0000_0104);
        check_eq("br_not_redirect", 32'(bus.redirect), 32'd0);
        set_idle();

        load_pc(32'h3000_0000);
        bus.jump_en     = 1'b1;
        bus.jump_target = 26'h40;
        bus.branch_en   = 1'b1;
        bus.branch_cond = 1'b1;
        bus.jr_en       = 1'b1;
        bus.jr_addr     = 32'h0000_0500;
        tick("prio");
        check_eq("prio_pc", bus.pc, 32'h0000_0500);
        bus.jr_en     = 1'b0;
        bus.branch_en = 1'b0;
        tick("jump");
        check_eq("jump_pc", bus.pc, 32'h0000_0100);
        set_idle();

        tick("pre_stall");
        bus.jump_en     = 1'b1;
        bus.jump_target = 26'h123;
        bus.stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check_eq("stall_pc", bus.pc, 32'h0000_0104);
            check_eq("stall_redirect", 32'(bus.redirect), 32'd0);
        end
        bus.stall = 1'b0;
        tick("unstall");
        check_eq("unstall_pc", bus.pc, 32'h0000_048C);
        set_idle();

        load_pc(32'hFFFF_FFFC);
        tick("wrap");
        check_eq("wrap_pc", bus.pc, 32'h0000_0000);

        load_pc(32'h0000_1000);
        tick("pre_rst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_pc", bus.pc, RESET_ADDR);
        check_eq("async_rst_valid", 32'(bus.pc_valid), 32'd0);
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("reboot");
        check_eq("reboot_pc", bus.pc, RESET_ADDR);
        tick("reboot_seq");

        bus.jr_en   = 1'b1;
        bus.jr_addr = 32'h0000_0203;
        tick("jr_mis");
        set_idle();
`ifdef PC_SEQ_ALIGN_TRAP_EN
        check_eq("trap_pc", bus.pc, 32'h0000_0080);
        check_eq("trap_epc", bus.epc, 32'h0000_0203);
        check_eq("trap_pulse", 32'(bus.trap), 32'd1);
        check_eq("trap_valid", 32'(bus.pc_valid), 32'd0);
        tick("trap_exit");
        check_eq("trap_exit_pc", bus.pc, 32'h0000_0080);
        check_eq("trap_exit_pulse", 32'(bus.trap), 32'd0);
        check_eq("trap_exit_valid", 32'(bus.pc_valid), 32'd1);
        tick("trap_fetch");
        check_eq("trap_fetch_pc", bus.pc, 32'h0000_0084);
        bus.jr_en   = 1'b1;
        bus.jr_addr = 32'h0000_0401;
        tick("trap2");
        set_idle();
        bus.stall = 1'b1;
        repeat (2) tick("trap_stall");
        check_eq("trap_stall_valid", 32'(bus.pc_valid), 32'd0);
        bus.stall = 1'b0;
        tick("trap_stall_exit");
`else
        check_eq("jr_mask_pc", bus.pc, 32'h0000_0200);
        check_eq("jr_mask_trap", 32'(bus.trap), 32'd0);
        check_eq("jr_mask_epc", bus.epc, 32'd0);
        tick("jr_mask_next");
        check_eq("jr_mask_next_pc", bus.pc, 32'h0000_0204);
`endif

        for (int i = 0; i < 400; i++) begin
            bus.stall         = ($urandom_range(0, 4) == 0);
            bus.jr_en         = ($urandom_range(0, 9) == 0);
            bus.jr_addr       = $urandom();
            bus.jump_en       = ($urandom_range(0, 9) == 0);
            bus.jump_target   = 26'($urandom());
            bus.branch_en     = ($urandom_range(0, 2) == 0);
            bus.branch_cond   = 1'($urandom());
            bus.branch_offset = 16'($urandom());
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
